// File: rtl/pipe_stage_if.sv
// Pipeline boundary bundle between a producing stage and a consuming stage.
//   in_valid / in_data   : producer's instruction and payload, into the stage register
//   out_valid / out_data : registered instruction and payload, to the consumer stage
// Modports:
//   master : the surrounding pipeline (drives in_*, observes out_*)
//   slave  : the stage register itself (reads in_*, drives out_*)
interface pipe_stage_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (output in_valid, output in_data, input out_valid, input out_data);
    modport slave  (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register for a stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Carries a packed payload plus valid bit. The register obeys the shared stall vector,
// inserts a NOP bubble when this stage stalls but the next one does not, and can
// be flushed. Saturating counters record hold, bubble and flush cycles.
// Ports:
//   clk, rst    : clock; synchronous active-high reset
//   stall       : shared stall vector; bit STALL_IDX is this stage (s_up), the next
//                 bit is the consuming stage (s_dn). STALL_IDX+1 must be < STALL_W.
//   flush       : kill the held/incoming instruction
//   cnt_clr     : synchronous clear of the three counters (wins over increments)
//   pif         : boundary bundle (in_valid/in_data in, out_valid/out_data out)
//   stall_cnt   : cycles spent holding
//   bubble_cnt  : bubbles inserted
//   flush_cnt   : flush cycles applied
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VAL   = '0,
    parameter int                STALL_W   = 5,
    parameter int                STALL_IDX = 2,
    parameter int                CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    pipe_stage_if.slave        pif,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } act_e;

    logic              s_up;
    logic              s_dn;
    act_e              act;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  bubble_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign s_up = stall[STALL_IDX];
    assign s_dn = stall[STALL_IDX+1];

    // Action decode. The unreachable !s_up & s_dn combination falls into LOAD.
    always_comb begin
        act = ACT_LOAD;
        if (flush)
            act = ACT_FLUSH;
        else if (s_up && !s_dn)
            act = ACT_BUBBLE;
        else if (s_up && s_dn)
            act = ACT_HOLD;
    end

    // Stage boundary: producer -> consumer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= NOP_VAL;
        end else begin
            case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    vld_p1  <= 1'b0;
                    data_p1 <= NOP_VAL;
                end
                ACT_LOAD: begin
                    vld_p1  <= pif.in_valid;
                    data_p1 <= pif.in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            case (act)
                ACT_FLUSH:  flush_cnt_q  <= sat_inc(flush_cnt_q);
                ACT_BUBBLE: bubble_cnt_q <= sat_inc(bubble_cnt_q);
                ACT_HOLD:   stall_cnt_q  <= sat_inc(stall_cnt_q);
                default: ;
            endcase
        end
    end

    assign pif.out_valid = vld_p1;
    assign pif.out_data  = data_p1;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a 16-bit-counter instance and a 2-bit-counter
// instance share clock, reset and control inputs.
module tb_pipe_stage_reg;
    localparam int                DATA_W = 64;
    localparam logic [DATA_W-1:0] NOP    = 64'h0000_0000_0000_DEAD;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] stall;
    logic       flush;
    logic       cnt_clr;
    logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
    logic [1:0]  s_stall_cnt, s_bubble_cnt, s_flush_cnt;

    int tests = 0;
    int fails = 0;

    pipe_stage_if #(.DATA_W(DATA_W)) pif_w ();
    pipe_stage_if #(.DATA_W(DATA_W)) pif_s ();

    pipe_stage_reg #(.DATA_W(DATA_W), .NOP_VAL(NOP), .STALL_W(5), .STALL_IDX(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .pif(pif_w.slave),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .NOP_VAL(NOP), .STALL_W(5), .STALL_IDX(2), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .pif(pif_s.slave),
        .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    // The stall controller must never stall downstream without stalling this stage.
    always @(posedge clk) begin
        if (rst === 1'b0)
            assert (!(!stall[2] && stall[3])) else $error("illegal stall vector %b", stall);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        pif_w.in_valid = v;
        pif_w.in_data  = d;
        pif_s.in_valid = v;
        pif_s.in_data  = d;
    endtask

    initial begin
        rst = 1'b1; stall = 5'b0; flush = 1'b0; cnt_clr = 1'b0;
        drive(1'b1, 64'hAB);
        @(negedge clk);

        // Reset held two cycles with a valid instruction presented.
        step(); step();
        check("rst_valid",  64'(pif_w.out_valid), 64'd0);
        check("rst_data",   pif_w.out_data, NOP);
        check("rst_stall",  64'(stall_cnt), 64'd0);
        check("rst_bubble", 64'(bubble_cnt), 64'd0);
        check("rst_flush",  64'(flush_cnt), 64'd0);
        rst = 1'b0;

        // Free-running loads, one-cycle latency.
        drive(1'b1, 64'h11); step();
        check("load11_data",  pif_w.out_data, 64'h11);
        check("load11_valid", 64'(pif_w.out_valid), 64'd1);
        drive(1'b1, 64'h22); step();
        check("load22_data",  pif_w.out_data, 64'h22);
        drive(1'b1, 64'h33); step();
        check("load33_data",  pif_w.out_data, 64'h33);
        check("load33_valid", 64'(pif_w.out_valid), 64'd1);

        // Bubbles: this stage stalled, next stage free.
        stall = 5'b00100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bubble_valid", 64'(pif_w.out_valid), 64'd0);
            check("bubble_data",  pif_w.out_data, NOP);
        end
        check("bubble_cnt3", 64'(bubble_cnt), 64'd3);
        check("bubble_stall_cnt0", 64'(stall_cnt), 64'd0);

        // Hold: both stalled, register keeps 0x55.
        stall = 5'b00000; drive(1'b1, 64'h55); step();
        check("load55_data", pif_w.out_data, 64'h55);
        stall = 5'b01100; drive(1'b1, 64'h66);
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_data",  pif_w.out_data, 64'h55);
            check("hold_valid", 64'(pif_w.out_valid), 64'd1);
        end
        check("stall_cnt4", 64'(stall_cnt), 64'd4);

        // Flush overrides the hold.
        flush = 1'b1; step();
        check("flush_valid", 64'(pif_w.out_valid), 64'd0);
        check("flush_data",  pif_w.out_data, NOP);
        check("flush_cnt1",  64'(flush_cnt), 64'd1);
        check("flush_stall_cnt", 64'(stall_cnt), 64'd4);
        flush = 1'b0; stall = 5'b0;

        // Load with in_valid low still captures the payload.
        drive(1'b0, 64'h77); step();
        check("inval_valid", 64'(pif_w.out_valid), 64'd0);
        check("inval_data",  pif_w.out_data, 64'h77);

        // Counter clear coinciding with a bubble; payload follows the bubble.
        stall = 5'b00100; cnt_clr = 1'b1; step();
        check("clr_bubble", 64'(bubble_cnt), 64'd0);
        check("clr_stall",  64'(stall_cnt), 64'd0);
        check("clr_flush",  64'(flush_cnt), 64'd0);
        check("clr_data",   pif_w.out_data, NOP);
        cnt_clr = 1'b0;

        // Reset during a hold starts clean; next cycle loads normally.
        stall = 5'b00000; drive(1'b1, 64'h88); step();
        stall = 5'b01100; step();
        check("pre_rst_stall", 64'(stall_cnt), 64'd1);
        rst = 1'b1; step();
        check("midrst_valid", 64'(pif_w.out_valid), 64'd0);
        check("midrst_data",  pif_w.out_data, NOP);
        check("midrst_stall", 64'(stall_cnt), 64'd0);
        rst = 1'b0; stall = 5'b0; drive(1'b1, 64'h99); step();
        check("postrst_data",  pif_w.out_data, 64'h99);
        check("postrst_valid", 64'(pif_w.out_valid), 64'd1);

        // Saturation on the 2-bit-counter instance, then clear against a bubble.
        stall = 5'b00100;
        for (int i = 0; i < 5; i++) step();
        check("sat_small_bubble", 64'(s_bubble_cnt), 64'd3);
        check("wide_bubble5",     64'(bubble_cnt), 64'd5);
        cnt_clr = 1'b1; step();
        check("sat_clr_bubble", 64'(s_bubble_cnt), 64'd0);
        cnt_clr = 1'b0; step();
        check("after_clr_bubble", 64'(s_bubble_cnt), 64'd1);
        stall = 5'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
